// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART TX engine: accepts bytes over valid/ready and
// issues the head byte as a one-cycle t_valid pulse. The byte is popped on tx_done.
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_valid,
    input  logic [7:0]    push_data,
    output logic          push_ready,
    output logic          t_valid,
    output logic [7:0]    t_data,
    input  logic          tx_done,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          idle
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic          t_valid_q, t_valid_d;
    logic [7:0]    t_data_q, t_data_d;
    logic          push_fire;
    logic          pop_fire;

    // The in-flight byte still counts as held, so a full FIFO never overwrites it.
    assign push_ready = (count_q != FULL_COUNT);
    assign empty      = (count_q == '0);
    assign idle       = empty && (state_q == S_IDLE);
    assign count      = count_q;
    assign t_valid    = t_valid_q;
    assign t_data     = t_data_q;

    always_comb begin
        push_fire = push_valid && push_ready;
        pop_fire  = (state_q == S_WAIT) && tx_done;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        t_valid_d = 1'b0;
        t_data_d  = t_data_q;

        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_fire && !pop_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_fire && pop_fire) begin
            count_d = count_q - CNT_ONE;
        end

        // tx_done outside S_WAIT is deliberately ignored.
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    t_data_d  = mem[rd_ptr_q];
                    t_valid_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            t_valid_q <= 1'b0;
            t_data_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            t_valid_q <= t_valid_d;
            t_data_q  <= t_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a vector table, directed corner sequences and
// random traffic, all compared against a queue-based reference model every cycle.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rstn;
    logic          push_valid;
    logic [7:0]    push_data;
    logic          push_ready;
    logic          t_valid;
    logic [7:0]    t_data;
    logic          tx_done;
    logic [AW:0]   count;
    logic          empty;
    logic          idle;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .t_valid    (t_valid),
        .t_data     (t_data),
        .tx_done    (tx_done),
        .count      (count),
        .empty      (empty),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bytes in order, plus whether the head is issued.
    logic [7:0] ref_q [$];
    bit         outst    = 1'b0;
    bit         just_iss = 1'b0;
    logic [7:0] exp_td   = 8'h00;
    logic [7:0] seen [$];
    int         pulses   = 0;

    typedef struct packed {
        logic       pv;
        logic [7:0] pd;
        logic       dn;
        logic       tv;
        logic [7:0] td;
        logic [4:0] cnt;
        logic       idl;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock: predict from the model, then compare every output.
    task automatic step();
        bit acc;
        bit pop;
        bit iss;
        if (!rstn) begin
            ref_q.delete();
            outst    = 1'b0;
            just_iss = 1'b0;
            exp_td   = 8'h00;
        end else begin
            acc = push_valid && (ref_q.size() < DEPTH);
            pop = outst && !just_iss && tx_done;
            iss = !outst && (ref_q.size() != 0);
            if (iss) exp_td = ref_q[0];
            if (pop) begin
                void'(ref_q.pop_front());
                outst = 1'b0;
            end
            if (acc) ref_q.push_back(push_data);
            if (iss) outst = 1'b1;
            just_iss = iss;
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(ref_q.size()));
        chk("t_valid", 32'(t_valid), 32'(just_iss));
        chk("t_data", 32'(t_data), 32'(exp_td));
        chk("push_ready", 32'(push_ready), 32'(ref_q.size() < DEPTH));
        chk("empty", 32'(empty), 32'(ref_q.size() == 0));
        chk("idle", 32'(idle), 32'(ref_q.size() == 0 && !outst));
        if (t_valid) begin
            seen.push_back(t_data);
            pulses++;
        end
        $display("cyc pv=%0d pd=%02h dn=%0d -> tv=%0d td=%02h cnt=%0d rdy=%0d idle=%0d",
                 push_valid, push_data, tx_done, t_valid, t_data, count, push_ready, idle);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        push_valid = 1'b0;
        push_data = 8'h00;
        tx_done = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic wait_waiting();
        int n = 0;
        while (!(outst && !just_iss) && n < 40) begin
            step();
            n++;
        end
        chk("wait_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic ack_one();
        wait_waiting();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int max_cnt;
        int pulses_before;

        tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1};
        tbl[9]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 5'd1, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 5'd1, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 5'd1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 5'd0, 1'b1};

        // Reset state
        do_reset();
        chk("rst count", 32'(count), 32'd0);
        chk("rst push_ready", 32'(push_ready), 32'd1);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst idle", 32'(idle), 32'd1);
        chk("rst t_valid", 32'(t_valid), 32'd0);
        chk("rst t_data", 32'(t_data), 32'd0);

        // Single byte, spurious tx_done in idle and issue states
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            push_valid = tbl[i].pv;
            push_data  = tbl[i].pd;
            tx_done    = tbl[i].dn;
            step();
            chk($sformatf("vec%0d t_valid", i), 32'(t_valid), 32'(tbl[i].tv));
            chk($sformatf("vec%0d t_data", i), 32'(t_data), 32'(tbl[i].td));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d idle", i), 32'(idle), 32'(tbl[i].idl));
        end
        push_valid = 1'b0;
        tx_done = 1'b0;
        chk("vec pulses", 32'(pulses), 32'd2);

        // Fill to full with tx_done withheld, then drain in order
        do_reset();
        seen.delete();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1;
            push_data = 8'(i);
            step();
        end
        chk("full count", 32'(count), 32'd16);
        chk("full push_ready", 32'(push_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            push_data = 8'hAA;
            step();
            chk("held count", 32'(count), 32'd16);
        end
        push_valid = 1'b0;
        for (int i = 0; i < 16; i++) ack_one();
        for (int i = 0; i < 4; i++) step();
        chk("fill pulses", 32'(pulses), 32'd16);
        chk("fill seen size", 32'(seen.size()), 32'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            chk($sformatf("fill order %0d", i), 32'(seen[i]), 32'(i));

        // Interleaved push/ack of 20 bytes across the pointer wrap
        do_reset();
        seen.delete();
        idx = 0;
        max_cnt = 0;
        for (int c = 0; c < 2000 && (idx < 20 || ref_q.size() != 0); c++) begin
            push_valid = (idx < 20) && ($urandom_range(0, 99) < 50);
            push_data = 8'(8'h10 + idx);
            tx_done = ($urandom_range(0, 99) < 40);
            if (push_valid && ref_q.size() < DEPTH) idx++;
            step();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        push_valid = 1'b0;
        tx_done = 1'b0;
        step();
        chk("wrap max count", 32'(max_cnt <= 16), 32'd1);
        chk("wrap seen size", 32'(seen.size()), 32'd20);
        for (int i = 0; i < 20 && i < seen.size(); i++)
            chk($sformatf("wrap order %0d", i), 32'(seen[i]), 32'(8'h10 + i));

        // Full FIFO with push and tx_done on the same edge
        do_reset();
        seen.delete();
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1;
            push_data = 8'(8'h60 + i);
            step();
        end
        push_data = 8'hBB;
        tx_done = 1'b1;
        step();
        chk("pushpop count", 32'(count), 32'd15);
        tx_done = 1'b0;
        step();
        chk("pushpop next count", 32'(count), 32'd16);
        push_valid = 1'b0;
        for (int i = 0; i < 16; i++) ack_one();
        chk("pushpop seen size", 32'(seen.size()), 32'd17);
        if (seen.size() == 17) chk("pushpop last", 32'(seen[16]), 32'h0BB);

        // Reset while a byte is in flight
        do_reset();
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_data = 8'(8'h71 + i);
            step();
        end
        push_valid = 1'b0;
        wait_waiting();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst t_valid", 32'(t_valid), 32'd0);
        chk("midrst idle", 32'(idle), 32'd1);
        pulses_before = pulses;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        chk("late done count", 32'(count), 32'd0);
        chk("late done idle", 32'(idle), 32'd1);
        chk("late done pulses", 32'(pulses), 32'(pulses_before));
        push_valid = 1'b1;
        push_data = 8'h55;
        step();
        push_valid = 1'b0;
        ack_one();
        chk("after rst byte", 32'(seen.size() > 0 ? seen[seen.size()-1] : 8'h00), 32'h55);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            push_valid = ($urandom_range(0, 99) < 60);
            push_data = 8'($urandom);
            tx_done = (outst && !just_iss) ? ($urandom_range(0, 99) < 30)
                                           : ($urandom_range(0, 99) < 10);
            step();
        end
        push_valid = 1'b0;
        tx_done = 1'b0;
        for (int g = 0; g < 40 && ref_q.size() != 0; g++) ack_one();
        step();
        chk("rand drained idle", 32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
